// File: rtl/instruction_cache_if.sv
// Fetch-side and fill-side signal bundle for the instruction cache.
// The slave modport is the cache; the master modport is the IF stage plus instruction memory.
interface instruction_cache_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_read;
  logic [WORD_SIZE-1:0] cpu_address;
  logic [WORD_SIZE-1:0] cpu_data;
  logic                 cpu_ready;
  logic                 invalidate;
  logic                 mem_read;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_valid;
  logic [WORD_SIZE-1:0] hit_count;
  logic [WORD_SIZE-1:0] miss_count;

  modport slave (
    input  cpu_read, cpu_address, invalidate, mem_data, mem_valid,
    output cpu_data, cpu_ready, mem_read, mem_address, hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_address, invalidate, mem_data, mem_valid,
    input  cpu_data, cpu_ready, mem_read, mem_address, hit_count, miss_count
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-line fill FSM on a miss.
// Hits return in the same cycle; a miss holds cpu_ready low until the line is filled and the fetch retried.
module instruction_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int WORD_SIZE  = 16
) (
  input  logic clk,
  input  logic reset_n,
  instruction_cache_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  state_t              state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                pend_q, pend_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  word_t               hit_cnt_q, hit_cnt_d;
  word_t               miss_cnt_q, miss_cnt_d;

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]    tag_q  [NUM_LINES];
  word_t               data_q [NUM_LINES][LINE_WORDS];
  logic                tag_we, data_we;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic                hit;
  logic                cpu_ready;
  word_t               cpu_data;
  logic                mem_read;
  word_t               mem_address;

  always_comb begin
    {req_tag, req_idx, req_off} = bus.cpu_address;
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    pend_d      = pend_q;
    fill_tag_d  = fill_tag_q;
    fill_idx_d  = fill_idx_q;
    cnt_d       = cnt_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    hit         = 1'b0;
    cpu_ready   = 1'b0;
    cpu_data    = '0;
    mem_read    = 1'b0;
    mem_address = '0;

    case (state_q)
      IDLE: begin
        hit = bus.cpu_read && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_data  = data_q[req_idx][req_off];
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + word_t'(1);
        end
        // The lookup above still saw the old valid bits.
        if (bus.invalidate) valid_d = '0;
        if (bus.cpu_read && !hit) begin
          fill_tag_d = req_tag;
          fill_idx_d = req_idx;
          cnt_d      = '0;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + word_t'(1);
          state_d    = FILL;
        end
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {fill_tag_q, fill_idx_q, cnt_q};
        if (bus.invalidate) pend_d = 1'b1;
        if (bus.mem_valid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            tag_we  = 1'b1;
            state_d = IDLE;
            // An invalidate seen during the fill discards this line along with all others.
            if (pend_q || bus.invalidate) begin
              valid_d = '0;
              pend_d  = 1'b0;
            end else begin
              valid_d[fill_idx_q] = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      pend_q     <= 1'b0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[fill_idx_q][cnt_q] <= bus.mem_data;
    if (tag_we)  tag_q[fill_idx_q]         <= fill_tag_q;
  end

  assign bus.cpu_ready   = cpu_ready;
  assign bus.cpu_data    = cpu_data;
  assign bus.mem_read    = mem_read;
  assign bus.mem_address = mem_address;
  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: line-residency reference model, fetch scoreboard and fill-address monitor.
module tb_instruction_cache;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;
  localparam int BOUND      = 200;

  logic clk;
  logic reset_n;
  instruction_cache_if #(.WORD_SIZE(16)) bus ();

  instruction_cache #(.LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES), .WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_data = bus.mem_address ^ 16'hA5A5;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;          // 0: zero wait, 1: every third cycle, 2: random
  int resident [NUM_LINES];  // line number held at each index, -1 if none
  int m_hits   = 0;
  int m_misses = 0;
  logic [15:0] exp_q [$];    // expected fetch data, in order
  int          fill_q [$];   // expected fill base addresses, in order
  int          wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) resident[i] = -1;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Memory responder: decides mem_valid for the current cycle just after each edge.
  initial begin
    int phase;
    phase = 0;
    bus.mem_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.mem_read) begin
        phase = 0;
        bus.mem_valid = 1'b0;
      end else begin
        phase++;
        case (mode)
          0:       bus.mem_valid = 1'b1;
          1:       bus.mem_valid = (phase % 3 == 0);
          default: bus.mem_valid = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Fetch monitor: pops the scoreboard whenever the cache presents a hit.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n && bus.cpu_read && bus.cpu_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 32'(bus.cpu_address), 32'hFFFF_FFFF);
        else chk("cpu_data", 32'(bus.cpu_data), 32'(exp_q.pop_front()));
      end else if (!bus.cpu_ready) begin
        chk("cpu_data_idle_zero", 32'(bus.cpu_data), 32'h0);
      end
    end
  end

  // Fill monitor: accepted words must walk the expected line from offset 0; address holds while waiting.
  initial begin
    logic        prev_wait;
    logic [15:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read && prev_wait) chk("mem_address_stable", 32'(bus.mem_address), 32'(prev_addr));
      if (bus.mem_read && bus.mem_valid) begin
        if (fill_q.size() == 0) chk("unexpected_fill", 32'(bus.mem_address), 32'hFFFF_FFFF);
        else begin
          chk("fill_address", 32'(bus.mem_address), 32'(fill_q[0] + wcnt));
          wcnt++;
          if (wcnt == LINE_WORDS) begin
            void'(fill_q.pop_front());
            wcnt = 0;
          end
        end
      end
      prev_wait = bus.mem_read && !bus.mem_valid;
      prev_addr = bus.mem_address;
    end
  end

  // One fetch held until served. inv_at: stall cycle in which invalidate is pulsed (-1 none).
  // chg: move cpu_address to another line mid-fill and restore it before the fill ends.
  task automatic fetch(input logic [15:0] a, input int inv_at, input bit chg);
    int  line, idx, fills, per_fill, exp_stall, stalls;
    bit  is_hit;
    line   = int'(a) / LINE_WORDS;
    idx    = line % NUM_LINES;
    is_hit = (resident[idx] == line);
    fills  = 0;
    if (!is_hit) fills = (inv_at >= 1 && inv_at <= LINE_WORDS) ? 2 : 1;
    per_fill  = (mode == 0) ? LINE_WORDS + 1 : (mode == 1) ? 3 * LINE_WORDS + 1 : -1;
    exp_stall = is_hit ? 0 : (per_fill < 0 ? -1 : fills * per_fill);
    for (int f = 0; f < fills; f++) fill_q.push_back(line * LINE_WORDS);
    m_misses += fills;
    m_hits++;
    if (inv_at >= 0) for (int i = 0; i < NUM_LINES; i++) resident[i] = -1;
    if (!is_hit) resident[idx] = line;
    exp_q.push_back(a ^ 16'hA5A5);

    bus.cpu_read    = 1'b1;
    bus.cpu_address = a;
    bus.invalidate  = (inv_at == 0);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.cpu_ready) break;
      if (stalls >= BOUND) begin
        chk("fetch_timeout", 32'(stalls), 32'(exp_stall));
        exp_q.delete();
        break;
      end
      @(posedge clk);
      #1;
      stalls++;
      bus.invalidate = (stalls == inv_at);
      if (chg && stalls == 2) bus.cpu_address = a ^ 16'h0040;
      if (chg && stalls == 5) bus.cpu_address = a;
    end
    @(posedge clk);
    #1;
    bus.invalidate = 1'b0;
    if (exp_stall >= 0) chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("hit_count", 32'(bus.hit_count), 32'(m_hits));
    chk("miss_count", 32'(bus.miss_count), 32'(m_misses));
  endtask

  task automatic pulse_invalidate();
    bus.cpu_read   = 1'b0;
    bus.invalidate = 1'b1;
    @(posedge clk);
    #1;
    bus.invalidate = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) resident[i] = -1;
  endtask

  initial begin
    reset_n         = 1'b1;
    bus.cpu_read    = 1'b0;
    bus.cpu_address = '0;
    bus.invalidate  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    chk("rst_cpu_data", 32'(bus.cpu_data), 32'h0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("rst_hit_count", 32'(bus.hit_count), 32'h0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'h0);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss with zero-wait memory, then hits on the rest of the line.
    mode = 0;
    fetch(16'h0012, -1, 1'b0);
    fetch(16'h0010, -1, 1'b0);
    fetch(16'h0011, -1, 1'b0);
    fetch(16'h0013, -1, 1'b0);
    chk("hit_count_after_line", 32'(bus.hit_count), 32'd4);

    // Invalidate in IDLE, then a same-index conflict sequence.
    pulse_invalidate();
    fetch(16'h0012, -1, 1'b0);
    fetch(16'h0052, -1, 1'b0);
    fetch(16'h0012, -1, 1'b0);

    // Invalidate in the hit cycle still hits; the neighbour word then misses.
    fetch(16'h0012, 0, 1'b0);
    fetch(16'h0013, -1, 1'b0);

    // Invalidate during a fill forces a second fill of the same line.
    fetch(16'h0020, 2, 1'b0);
    fetch(16'h0021, -1, 1'b0);

    // Slow memory with the fetch address wandering mid-fill.
    mode = 1;
    fetch(16'h0130, -1, 1'b1);
    fetch(16'h0133, -1, 1'b0);

    // Random addresses, random memory wait states, occasional invalidate.
    mode = 2;
    for (int n = 0; n < 40; n++)
      fetch(16'($urandom_range(0, 127)), ($urandom_range(0, 9) == 0) ? 0 : -1, 1'b0);

    // Reset in the middle of a fill.
    mode = 0;
    fill_q.push_back(16'h0200);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 16'h0200;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_fill_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_fill_hit_count", 32'(bus.hit_count), 32'h0);
    chk("rst_fill_miss_count", 32'(bus.miss_count), 32'h0);
    chk("rst_fill_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    bus.cpu_read = 1'b0;
    fill_q.delete();
    wcnt = 0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1;
    fetch(16'h0200, -1, 1'b0);
    fetch(16'h0203, -1, 1'b0);

    bus.cpu_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("fills_drained", 32'(fill_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
